// File: rtl/lsu_types.sv
// lsu_types: state and error encodings for the rv32i load/store unit.
package lsu_types;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } lsu_state_t;

  // Values are visible on core_rsp_error, so the encoding is fixed.
  typedef enum logic [1:0] {
    LSU_OK         = 2'd0,
    LSU_MISALIGNED = 2'd1,
    LSU_ILLEGAL    = 2'd2,
    LSU_TIMEOUT    = 2'd3
  } lsu_err_t;

endpackage

// File: rtl/rv32i_defines.sv
// rv32i_defines: shared RV32I encodings used by the core and its satellites.
// This slice contains only the funct3 values for loads and stores.
package rv32i_defines;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: purely combinational load data extraction.
// Ports:
//   rd_word  - word returned by memory
//   byte_off - byte address bits [1:0] of the load
//   funct3   - load type (LB/LH/LW/LBU/LHU)
//   result   - selected lane, sign- or zero-extended to 32 bits
module lsu_load_align
  import rv32i_defines::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Bring the addressed byte down to bit 0; halfwords only need addr[1].
    shifted = rd_word >> {byte_off, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    result  = 32'h0;
    case (funct3)
      F3_LB:   result = {{24{lane_b[7]}}, lane_b};
      F3_LH:   result = {{16{lane_h[15]}}, lane_h};
      F3_LW:   result = rd_word;
      F3_LBU:  result = {24'h0, lane_b};
      F3_LHU:  result = {16'h0, lane_h};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit between the core data port and a word-addressed,
// byte-enabled memory. One transaction at a time; loads are bounded by a
// response timeout.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   core_req_*         - core request (valid/ready, write, funct3, addr, wdata)
//   core_rsp_*         - one-cycle completion pulse with rdata and error code
//   mem_req_*          - memory request (valid/ready), word address, write
//                        enable, byte enables, lane-replicated write data
//   mem_rsp_valid/
//   mem_rd_data        - memory read response
module rv32i_lsu
  import rv32i_defines::*;
  import lsu_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic        core_req_write,
  input  logic [2:0]  core_req_funct3,
  input  logic [31:0] core_req_addr,
  input  logic [31:0] core_req_wdata,
  output logic        core_rsp_valid,
  output logic [31:0] core_rsp_rdata,
  output logic [1:0]  core_rsp_error,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [29:0] mem_word_addr,
  output logic        mem_wr_ena,
  output logic [3:0]  mem_byte_ena,
  output logic [31:0] mem_wr_data,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rd_data
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic        write_reg;
  logic [31:0] wr_data_reg;
  logic [3:0]  byte_ena_reg;
  logic        wr_ena_reg;
  logic [31:0] rdata_reg;
  lsu_err_t    err_reg;
  logic [7:0]  cnt_reg;
  logic        stale_reg;

  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] fmt_wr_data;
  logic [3:0]  fmt_byte_ena;
  logic [31:0] load_result;
  logic        accept;
  logic        rsp_take;
  logic        tmo_hit;

  // Request decode on the live core inputs, captured at acceptance.
  always_comb begin
    req_illegal = 1'b0;
    if (core_req_write) begin
      req_illegal = (core_req_funct3 > F3_SW);
    end else begin
      case (core_req_funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: req_illegal = 1'b0;
        default:                             req_illegal = 1'b1;
      endcase
    end
    // funct3[1:0] gives the access size for both loads and stores.
    req_misaligned = ((core_req_funct3[1:0] == 2'b01) && core_req_addr[0]) ||
                     ((core_req_funct3[1:0] == 2'b10) && (core_req_addr[1:0] != 2'b00));
  end

  // Store lane replication; loads always read the full word.
  always_comb begin
    fmt_wr_data  = 32'h0;
    fmt_byte_ena = 4'b1111;
    if (core_req_write) begin
      case (core_req_funct3[1:0])
        2'b00: begin
          fmt_wr_data  = {4{core_req_wdata[7:0]}};
          fmt_byte_ena = 4'b0001 << core_req_addr[1:0];
        end
        2'b01: begin
          fmt_wr_data  = {2{core_req_wdata[15:0]}};
          fmt_byte_ena = 4'b0011 << core_req_addr[1:0];
        end
        default: begin
          fmt_wr_data  = core_req_wdata;
          fmt_byte_ena = 4'b1111;
        end
      endcase
    end
  end

  lsu_load_align u_load_align (
    .rd_word  (mem_rd_data),
    .byte_off (addr_reg[1:0]),
    .funct3   (funct3_reg),
    .result   (load_result)
  );

  assign accept   = (state_reg == IDLE) && core_req_valid;
  // A response arriving while stale is the late answer to a timed-out load.
  assign rsp_take = (state_reg == WAIT_RSP) && mem_rsp_valid && !stale_reg;
  assign tmo_hit  = (state_reg == WAIT_RSP) && !rsp_take && (cnt_reg == TMO_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (core_req_valid) begin
          state_next = (req_illegal || req_misaligned) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_next = write_reg ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_take || tmo_hit) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 32'h0;
      funct3_reg   <= 3'h0;
      write_reg    <= 1'b0;
      wr_data_reg  <= 32'h0;
      byte_ena_reg <= 4'h0;
      wr_ena_reg   <= 1'b0;
      rdata_reg    <= 32'h0;
      err_reg      <= LSU_OK;
      cnt_reg      <= 8'h0;
      stale_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        addr_reg     <= core_req_addr;
        funct3_reg   <= core_req_funct3;
        write_reg    <= core_req_write;
        wr_data_reg  <= fmt_wr_data;
        byte_ena_reg <= fmt_byte_ena;
        wr_ena_reg   <= core_req_write;
        if (req_illegal) begin
          err_reg   <= LSU_ILLEGAL;
          rdata_reg <= 32'h0;
        end else if (req_misaligned) begin
          err_reg   <= LSU_MISALIGNED;
          rdata_reg <= 32'h0;
        end
      end

      if ((state_reg == ISSUE) && mem_req_ready) begin
        cnt_reg <= 8'h0;
        if (write_reg) begin
          err_reg   <= LSU_OK;
          rdata_reg <= 32'h0;
        end
      end

      // Any response seen while stale is consumed here; a timeout in the
      // same cycle re-arms the flag below.
      if (mem_rsp_valid && stale_reg) begin
        stale_reg <= 1'b0;
      end

      if (rsp_take) begin
        rdata_reg <= load_result;
        err_reg   <= LSU_OK;
      end else if (tmo_hit) begin
        rdata_reg <= 32'h0;
        err_reg   <= LSU_TIMEOUT;
        stale_reg <= 1'b1;
      end else if ((state_reg == WAIT_RSP) && (cnt_reg != 8'hFF)) begin
        cnt_reg <= cnt_reg + 8'h1;
      end
    end
  end

  assign core_req_ready = (state_reg == IDLE);
  assign core_rsp_valid = (state_reg == DONE);
  assign core_rsp_rdata = rdata_reg;
  assign core_rsp_error = err_reg;
  assign mem_req_valid  = (state_reg == ISSUE);
  assign mem_word_addr  = addr_reg[31:2];
  assign mem_wr_ena     = wr_ena_reg;
  assign mem_byte_ena   = byte_ena_reg;
  assign mem_wr_data    = wr_data_reg;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: directed and randomized transactions against a
// transaction-level model of the load/store unit.
module tb_rv32i_lsu;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid;
  logic        core_req_ready;
  logic        core_req_write;
  logic [2:0]  core_req_funct3;
  logic [31:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic        core_rsp_valid;
  logic [31:0] core_rsp_rdata;
  logic [1:0]  core_rsp_error;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_word_addr;
  logic        mem_wr_ena;
  logic [3:0]  mem_byte_ena;
  logic [31:0] mem_wr_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32i_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .rst             (rst),
    .core_req_valid  (core_req_valid),
    .core_req_ready  (core_req_ready),
    .core_req_write  (core_req_write),
    .core_req_funct3 (core_req_funct3),
    .core_req_addr   (core_req_addr),
    .core_req_wdata  (core_req_wdata),
    .core_rsp_valid  (core_rsp_valid),
    .core_rsp_rdata  (core_rsp_rdata),
    .core_rsp_error  (core_rsp_error),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_word_addr   (mem_word_addr),
    .mem_wr_ena      (mem_wr_ena),
    .mem_byte_ena    (mem_byte_ena),
    .mem_wr_data     (mem_wr_data),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rd_data     (mem_rd_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction. The model computes error, data, lanes and
  // latency from the ISA rules; the loop plays the memory side.
  task automatic run_txn(input string name, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall, input bit respond, input bit early,
                         input logic [31:0] early_word, input logic [31:0] word);
    int          size, off, elat, stall_left, cyc, lat, req_cycles, since_acc;
    bit          legal, done, acc_seen;
    logic [1:0]  eerr;
    logic [31:0] ebe, ewd, erd, mask, v;

    size  = 1 << (f3 % 4);
    off   = addr % 4;
    legal = wr ? (f3 <= 2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    eerr  = !legal ? 2'd2 : ((addr % size) != 0) ? 2'd1 : 2'd0;
    ebe   = 32'hF;
    ewd   = 32'h0;
    erd   = 32'h0;
    if (wr) begin
      ebe = ((32'd1 << size) - 1) << off;
      if (size == 1)      ewd = wdata[7:0] * 32'h0101_0101;
      else if (size == 2) ewd = wdata[15:0] * 32'h0001_0001;
      else                ewd = wdata;
    end
    if (eerr != 0)     elat = 1;
    else if (wr)       elat = 2 + stall;
    else if (!respond) begin
      elat = 2 + stall + TMO;
      eerr = 2'd3;
    end else begin
      elat = 3 + stall + (early ? 1 : 0);
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
      v    = (word >> (8 * off)) & mask;
      if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
      erd  = v;
    end

    @(negedge clk);
    chk({name, ":req_ready"}, core_req_ready, 1);
    core_req_valid  = 1'b1;
    core_req_write  = wr;
    core_req_funct3 = f3;
    core_req_addr   = addr;
    core_req_wdata  = wdata;
    @(posedge clk);
    cyc = 0; lat = 0; req_cycles = 0; since_acc = 0;
    done = 0; acc_seen = 0; stall_left = stall;
    while (!done && cyc < 60) begin
      @(negedge clk);
      core_req_valid = 1'b0;
      mem_rsp_valid  = 1'b0;
      if (acc_seen) begin
        since_acc++;
        if (respond && !wr) begin
          if (early && since_acc == 1) begin
            mem_rsp_valid = 1'b1; mem_rd_data = early_word;
          end else if (since_acc == (early ? 2 : 1)) begin
            mem_rsp_valid = 1'b1; mem_rd_data = word;
          end
        end
      end
      if (mem_req_valid) begin
        req_cycles++;
        chk({name, ":word_addr"}, {2'b00, mem_word_addr}, addr >> 2);
        chk({name, ":wr_ena"}, mem_wr_ena, wr);
        chk({name, ":byte_ena"}, mem_byte_ena, ebe);
        if (wr) chk({name, ":wr_data"}, mem_wr_data, ewd);
        mem_req_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
        if (mem_req_ready) begin
          acc_seen  = 1;
          since_acc = 0;
        end
      end
      if (core_rsp_valid) begin
        lat  = cyc + 1;
        done = 1;
      end
      cyc++;
    end
    chk({name, ":completed"}, done, 1);
    chk({name, ":latency"}, lat, elat);
    chk({name, ":error"}, core_rsp_error, eerr);
    chk({name, ":rdata"}, core_rsp_rdata, erd);
    chk({name, ":mem_req_cycles"}, req_cycles, (eerr == 1 || eerr == 2) ? 0 : stall + 1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    chk({name, ":pulse_one_cycle"}, core_rsp_valid, 0);
    chk({name, ":ready_after"}, core_req_ready, 1);
    chk({name, ":rdata_hold"}, core_rsp_rdata, erd);
    chk({name, ":error_hold"}, core_rsp_error, eerr);
    $display("txn %s wr=%0d f3=%0d addr=%h lat=%0d err=%0d rdata=%h", name, wr, f3, addr,
             lat, core_rsp_error, core_rsp_rdata);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ":req_ready"}, core_req_ready, 1);
    chk({name, ":mem_req_valid"}, mem_req_valid, 0);
    chk({name, ":rsp_valid"}, core_rsp_valid, 0);
    chk({name, ":rdata"}, core_rsp_rdata, 0);
    chk({name, ":error"}, core_rsp_error, 0);
    chk({name, ":wr_ena"}, mem_wr_ena, 0);
    chk({name, ":byte_ena"}, mem_byte_ena, 0);
    chk({name, ":word_addr"}, {2'b00, mem_word_addr}, 0);
    chk({name, ":wr_data"}, mem_wr_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    core_req_valid  = 1'b0;
    core_req_write  = 1'b0;
    core_req_funct3 = 3'd0;
    core_req_addr   = 32'h0;
    core_req_wdata  = 32'h0;
    mem_req_ready   = 1'b1;
    mem_rsp_valid   = 1'b0;
    mem_rd_data     = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("post_reset");

    run_txn("lb_sext",   1'b0, 3'd0, 32'h0000_0103, 32'h0, 0, 1, 0, 32'h0, 32'h80FF_1234);
    run_txn("lhu_zext",  1'b0, 3'd5, 32'h0000_0102, 32'h0, 0, 1, 0, 32'h0, 32'hBEEF_0001);
    run_txn("sh_fmt",    1'b1, 3'd1, 32'h0000_0202, 32'h1234_5678, 0, 1, 0, 32'h0, 32'h0);
    run_txn("sb_fmt",    1'b1, 3'd0, 32'h0000_0011, 32'hCAFE_BEA5, 0, 1, 0, 32'h0, 32'h0);
    run_txn("sw_fmt",    1'b1, 3'd2, 32'h0000_0040, 32'hA1B2_C3D4, 1, 1, 0, 32'h0, 32'h0);
    run_txn("lw_misal",  1'b0, 3'd2, 32'h0000_0101, 32'h0, 0, 1, 0, 32'h0, 32'h0);
    run_txn("s_illegal", 1'b1, 3'd3, 32'h0000_0101, 32'h5555_AAAA, 0, 1, 0, 32'h0, 32'h0);
    run_txn("l_illegal", 1'b0, 3'd6, 32'h0000_0200, 32'h0, 0, 1, 0, 32'h0, 32'h0);
    run_txn("lw_bp",     1'b0, 3'd2, 32'h0000_0400, 32'h0, 5, 1, 0, 32'h0, 32'h0BAD_F00D);
    run_txn("lw_tmo",    1'b0, 3'd2, 32'h0000_0300, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    run_txn("lw_stale",  1'b0, 3'd2, 32'h0000_0304, 32'h0, 0, 1, 1, 32'hDEAD_BEEF, 32'h1122_3344);

    // A response while idle must not produce a completion.
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rd_data   = 32'h7777_7777;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("idle_rsp:rsp_valid", core_rsp_valid, 0);
    run_txn("lh_after",  1'b0, 3'd1, 32'h0000_0106, 32'h0, 0, 1, 0, 32'h0, 32'h8001_4321);

    // Reset asserted while a store is being held in ISSUE.
    @(negedge clk);
    core_req_valid  = 1'b1;
    core_req_write  = 1'b1;
    core_req_funct3 = 3'd2;
    core_req_addr   = 32'h0000_0ABC;
    core_req_wdata  = 32'h1357_9BDF;
    mem_req_ready   = 1'b0;
    @(negedge clk);
    core_req_valid  = 1'b0;
    chk("rst_mid:issue", mem_req_valid, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid:req_drop", mem_req_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid:no_rsp", core_rsp_valid, 0);
    end
    chk_reset_state("rst_mid");
    rst           = 1'b1;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid:no_rsp_after", core_rsp_valid, 0);
    $display("txn rst_mid reset during ISSUE");

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
              $urandom, $urandom_range(0, 2), 1, 0, 32'h0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
